// File: rtl/image_stream_ctrl_pkg.sv
// Shared image geometry, pixel/address widths and stream FSM encodings for the CNN input path.
package image_stream_ctrl_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int IMG_PIXELS = IMG_W * IMG_H;
  localparam int PIX_W      = 8;
  localparam int ADDR_W     = 10;
  localparam int COL_W      = 5;
  localparam int ROW_W      = 5;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/image_stream_ctrl_raster_counter.sv
// Raster-order col/row/address counter; advances on en, clr has priority, wraps after the last pixel.
module image_stream_ctrl_raster_counter
  import image_stream_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              sof,
  output logic              eol,
  output logic              eof
);

  assign sof = (col == '0) && (row == '0);
  assign eol = (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      if (eof) begin
        // Wrap instead of running past the last pixel address.
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (eol) begin
        col  <= '0;
        row  <= row + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_stream_ctrl.sv
// Streams one 28x28 frame from a combinational image ROM per start, with row/col tags and frame/line markers.
module image_stream_ctrl
  import image_stream_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic signed [PIX_W-1:0] rom_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [PIX_W-1:0] m_data,
  output logic [ROW_W-1:0]        m_row,
  output logic [COL_W-1:0]        m_col,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic                    m_eof
);

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              done_nxt;
  logic              go_idle;
  logic [COL_W-1:0]  cnt_col;
  logic [ROW_W-1:0]  cnt_row;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_sof;
  logic              cnt_eol;
  logic              cnt_eof;

  assign busy     = (state != ST_IDLE);
  assign rom_addr = cnt_addr;
  assign go_idle  = abort && (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        load = !m_valid || m_ready;
        if (abort)                  state_nxt = ST_IDLE;
        else if (load && cnt_eof)   state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (m_valid && m_ready) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter parks at pixel 0 whenever the FSM is (or is about to be) idle.
  image_stream_ctrl_raster_counter u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_nxt == ST_IDLE),
    .en   (load && !abort),
    .col  (cnt_col),
    .row  (cnt_row),
    .addr (cnt_addr),
    .sof  (cnt_sof),
    .eol  (cnt_eol),
    .eof  (cnt_eof)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_row   <= '0;
      m_col   <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else begin
      done <= done_nxt;
      if (go_idle) begin
        m_valid <= 1'b0;
      end else if (load) begin
        m_valid <= 1'b1;
        m_data  <= rom_data;
        m_row   <= cnt_row;
        m_col   <= cnt_col;
        m_sof   <= cnt_sof;
        m_eol   <= cnt_eol;
        m_eof   <= cnt_eof;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
